keypad_scan: RTL and testbench
==============================

# keypad_scan

Input-side counterpart of the seven-segment scan driver. It drives a 4x4 matrix keypad's rows one at a time, active-low, using the same one-cold pattern and order as the display anode scan. It reads the active-low column lines, debounces across whole scan frames, and reports each accepted key press once as a 4-bit code with a one-cycle valid strobe. It sits between the keypad pins and user logic.

## Interface
- SCAN_DIV, default 4: clock cycles each row is driven. Legal range is SCAN_DIV >= 4.
- DEBOUNCE_FRAMES, default 3: consecutive identical frames required to accept a press or a release. Legal range is 1..255.

- clk  input  1  system clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- col  input  4  keypad columns, active-low (pulled up externally); asynchronous to clk.
- row  output  4  keypad rows, one-cold active-low drive.
- key_code  output  4  code of the last accepted key, row*4 + column.
- key_valid  output  1  one-cycle pulse when a press is accepted.
- key_held  output  1  high from acceptance until release is accepted.

## Operation
- **Column synchroniser:** col passes through a 2-flop synchroniser; the result is col_s. Only col_s is used.
- **Row scan**
  - The divider counts 0..SCAN_DIV-1 and wraps.
  - On the edge where the divider = SCAN_DIV-1, col_s is sampled for the current row. On that same edge the row index advances 0→1→2→3→0.
  - row output by index: 0 → 1110, 1 → 1101, 2 → 1011, 3 → 0111.
  - Frame = 4 rows = 4*SCAN_DIV cycles. The frame ends at the row-3 sample.
- **Frame result**
  - Within a frame, the first pressed position in scan order is captured: lowest row first, then lowest column bit.
  - Pressed position = col_s bit 0 while its row is driven.
  - Result at frame end is either NONE or code = row*4+col.
  - Multiple keys pressed: the lowest code wins.
- **Debounce FSM.** It is evaluated only at frame end; the frame counter saturates at DEBOUNCE_FRAMES.
  - IDLE
    - NONE: stay.
    - Code c: cand=c, cnt=1, go to PRESS_WAIT. If DEBOUNCE_FRAMES=1, accept immediately as below.
  - PRESS_WAIT
    - NONE: go to IDLE.
    - Code ≠ cand: cand=new code, cnt=1.
    - Code = cand: cnt+1. When cnt reaches DEBOUNCE_FRAMES, accept: key_code=cand, pulse key_valid, key_held=1, go to HELD.
  - HELD
    - Any code, same or different: cnt=0, stay. No new key is reported while held.
    - NONE: cnt+1. When cnt reaches DEBOUNCE_FRAMES, key_held=0, go to IDLE.
- key_code holds its value after release until the next acceptance.
- Reset values: row=1110, divider=0, row index=0, synchroniser=1111, key_code=0000, key_valid=0, key_held=0, FSM=IDLE, cand=0, cnt=0.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronous assert). A pending candidate is discarded; no pulse is produced.

## Timing
- row changes one cycle after the sample edge. It is stable for SCAN_DIV cycles, which gives SCAN_DIV-1 cycles of settle plus synchroniser delay before the next sample.
- key_valid is high for exactly one clk cycle: the cycle after the row-3 sample edge of the qualifying frame. key_held rises in that same cycle.
- Press latency, from a stable press to key_valid: between (DEBOUNCE_FRAMES-1)*4*SCAN_DIV+1 and DEBOUNCE_FRAMES*4*SCAN_DIV+4*SCAN_DIV cycles, depending on press phase.
- key_held falls in the cycle after the row-3 sample edge of the DEBOUNCE_FRAMES-th consecutive NONE frame.
- Release of rst_n is synchronous to clk via the standard release path. The first sample occurs at cycle SCAN_DIV after release.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE_FRAMES=3, frame = 16 cycles.
- **Reset and scan sequence.** rst_n low, then high, with col=1111 → row=1110 during reset. row steps 1110, 1101, 1011, 0111, each for 4 cycles, and returns to 1110 after 16 cycles. key_valid=0 and key_held=0 throughout.
- **Single press.** Hold col[1]=0 only while row=1011 for 5 frames → exactly one key_valid pulse with key_code=9 after the 3rd complete frame. key_held=1 thereafter; no further pulses.
- **Bounce rejection.** Key 9 pressed 2 frames, released 1 frame, pressed 3 frames → no pulse after the first burst. Exactly one pulse with code 9 at the end of the 3-frame run.
- **Multi-key priority.** Keys 3 (row 0, col 3) and 12 (row 3, col 0) pressed together for 3 frames → single pulse with key_code=3.
- **Release and lockout.** While key 9 is held, press key 5 for 2 frames → no pulse, key_held stays 1. Then NONE for 2 frames, key 5 for 1 frame, NONE for 3 frames → key_held falls only after the final 3 NONE frames. key_code stays 9.
- **Reset mid-debounce.** Key 6 pressed 2 frames, then rst_n pulsed low in frame 3 → outputs reset asynchronously, no key_valid. After release, key 6 needs 3 fresh frames before its pulse.

Source files
------------

// File: rtl/keypad_scan_if.sv
// Keypad pin and key-event bundle between the scanner and its surroundings.
interface keypad_scan_if;
    logic [3:0] col;
    logic [3:0] row;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    // Scanner side: drives rows and key events, reads columns
    modport master (
        input  col,
        output row,
        output key_code,
        output key_valid,
        output key_held
    );

    // Pin/consumer side
    modport slave (
        output col,
        input  row,
        input  key_code,
        input  key_valid,
        input  key_held
    );
endinterface

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: one-cold active-low row drive, synchronised
// active-low column read, frame-based debounce, one strobe per accepted press.
module keypad_scan #(
    parameter int unsigned SCAN_DIV        = 4,
    parameter int unsigned DEBOUNCE_FRAMES = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    keypad_scan_if.master kp
);

    localparam int unsigned DIV_W = $clog2(SCAN_DIV);
    localparam int unsigned CNT_W = 8;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEB_N    = CNT_W'(DEBOUNCE_FRAMES);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PRESS_WAIT,
        ST_HELD
    } state_t;

    logic [3:0]       col_meta;
    logic [3:0]       col_s;
    logic [DIV_W-1:0] div_q;
    logic [1:0]       row_idx_q;
    logic [3:0]       row_q;
    logic             hit_q;
    logic [3:0]       hit_code_q;

    state_t           state_q, state_d;
    logic [3:0]       cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;

    logic             sample_c;
    logic             frame_end_c;
    logic             col_hit_c;
    logic [1:0]       col_pos_c;
    logic [3:0]       row_code_c;
    logic             frame_hit_c;
    logic [3:0]       frame_code_c;
    logic [CNT_W-1:0] cnt_inc_c;

    // Two-flop synchroniser for the asynchronous column lines
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta <= 4'hF;
            col_s    <= 4'hF;
        end else begin
            col_meta <= kp.col;
            col_s    <= col_meta;
        end
    end

    assign sample_c    = (div_q == DIV_LAST);
    assign frame_end_c = sample_c && (row_idx_q == 2'd3);

    // Row dwell divider, row index and registered one-cold row drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            row_idx_q <= 2'd0;
            row_q     <= 4'b1110;
        end else if (sample_c) begin
            div_q     <= '0;
            row_idx_q <= row_idx_q + 2'd1;
            row_q     <= ~(4'b0001 << (row_idx_q + 2'd1));
        end else begin
            div_q     <= div_q + DIV_W'(1);
        end
    end

    // Lowest pressed column in the currently driven row
    always_comb begin
        col_pos_c = 2'd0;
        casez (col_s)
            4'b???0: col_pos_c = 2'd0;
            4'b??01: col_pos_c = 2'd1;
            4'b?011: col_pos_c = 2'd2;
            4'b0111: col_pos_c = 2'd3;
            default: col_pos_c = 2'd0;
        endcase
    end

    assign col_hit_c    = (col_s != 4'hF);
    assign row_code_c   = {row_idx_q, col_pos_c};
    assign frame_hit_c  = hit_q | col_hit_c;
    assign frame_code_c = hit_q ? hit_code_q : row_code_c;

    // Capture the first pressed position of the frame; cleared at frame end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_q      <= 1'b0;
            hit_code_q <= 4'd0;
        end else if (frame_end_c) begin
            hit_q      <= 1'b0;
            hit_code_q <= 4'd0;
        end else if (sample_c && !hit_q && col_hit_c) begin
            hit_q      <= 1'b1;
            hit_code_q <= row_code_c;
        end
    end

    // Frame counter increment, saturating at the debounce length
    assign cnt_inc_c = (cnt_q >= DEB_N) ? DEB_N : cnt_q + CNT_W'(1);

    // Debounce next-state and output logic, evaluated at frame end only
    always_comb begin
        state_d     = state_q;
        cand_d      = cand_q;
        cnt_d       = cnt_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        if (frame_end_c) begin
            case (state_q)
                ST_IDLE: begin
                    if (frame_hit_c) begin
                        cand_d = frame_code_c;
                        if (DEB_N <= CNT_W'(1)) begin
                            key_code_d  = frame_code_c;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            cnt_d       = '0;
                            state_d     = ST_HELD;
                        end else begin
                            cnt_d   = CNT_W'(1);
                            state_d = ST_PRESS_WAIT;
                        end
                    end
                end
                ST_PRESS_WAIT: begin
                    if (!frame_hit_c) begin
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else if (frame_code_c != cand_q) begin
                        cand_d = frame_code_c;
                        cnt_d  = CNT_W'(1);
                    end else if (cnt_inc_c >= DEB_N) begin
                        key_code_d  = cand_q;
                        key_valid_d = 1'b1;
                        key_held_d  = 1'b1;
                        cnt_d       = '0;
                        state_d     = ST_HELD;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
                ST_HELD: begin
                    if (frame_hit_c) begin
                        cnt_d = '0;
                    end else if (cnt_inc_c >= DEB_N) begin
                        key_held_d = 1'b0;
                        cnt_d      = '0;
                        state_d    = ST_IDLE;
                    end else begin
                        cnt_d = cnt_inc_c;
                    end
                end
                default: begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // Debounce state and registered key outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            cand_q      <= 4'd0;
            cnt_q       <= '0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cand_q      <= cand_d;
            cnt_q       <= cnt_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign kp.row       = row_q;
    assign kp.key_code  = key_code_q;
    assign kp.key_valid = key_valid_q;
    assign kp.key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a behavioural 4x4 key matrix.
module tb_keypad_scan;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] pressed;
    logic [3:0]  col_c;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          pulses  = 0;
    int          base;
    logic [3:0]  exp_rows [4] = '{4'hE, 4'hD, 4'hB, 4'h7};

    keypad_scan_if kp_if ();

    keypad_scan #(
        .SCAN_DIV        (4),
        .DEBOUNCE_FRAMES (3)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .kp    (kp_if.master)
    );

    always #5 clk = ~clk;

    // Key matrix: a pressed key pulls its column low while its row is driven
    always_comb begin
        col_c = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!kp_if.row[r] && pressed[r*4+c]) col_c[c] = 1'b0;
    end
    assign kp_if.col = col_c;

    // Count key_valid strobes
    always @(negedge clk) if (kp_if.key_valid === 1'b1) pulses++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_frames(input int n);
        wait_cycles(16 * n);
    endtask

    function automatic logic [15:0] key_bit(input int k);
        return 16'(1) << k;
    endfunction

    initial begin
        pressed = '0;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_row",   32'(kp_if.row), 32'hE);
        check("rst_valid", 32'(kp_if.key_valid), 0);
        check("rst_held",  32'(kp_if.key_held), 0);
        check("rst_code",  32'(kp_if.key_code), 0);
        rst_n = 1'b1;

        // Scan sequence: each row 4 cycles, back to row 0 after 16
        check("scan_row_k0", 32'(kp_if.row), 32'hE);
        for (int k = 1; k <= 16; k++) begin
            wait_cycles(1);
            check($sformatf("scan_row_k%0d", k), 32'(kp_if.row), 32'(exp_rows[(k/4)%4]));
        end
        check("scan_pulses", pulses, 0);
        check("scan_held", 32'(kp_if.key_held), 0);

        // Single press of key 9 for 5 frames
        pressed = key_bit(9);
        wait_frames(2);
        check("single_f2_valid", 32'(kp_if.key_valid), 0);
        check("single_f2_pulses", pulses, 0);
        wait_frames(1);
        check("single_valid", 32'(kp_if.key_valid), 1);
        check("single_code", 32'(kp_if.key_code), 9);
        check("single_held", 32'(kp_if.key_held), 1);
        wait_cycles(1);
        check("single_valid_drop", 32'(kp_if.key_valid), 0);
        wait_cycles(15);
        wait_frames(2);
        check("single_pulses", pulses, 1);
        check("single_held_still", 32'(kp_if.key_held), 1);
        pressed = '0;
        wait_frames(2);
        check("single_rel2_held", 32'(kp_if.key_held), 1);
        wait_frames(1);
        check("single_rel3_held", 32'(kp_if.key_held), 0);
        check("single_code_kept", 32'(kp_if.key_code), 9);

        // Bounce: 2 frames, 1 gap, 3 frames
        base = pulses;
        pressed = key_bit(9);
        wait_frames(2);
        pressed = '0;
        wait_frames(1);
        check("bounce_burst_pulses", pulses, base);
        pressed = key_bit(9);
        wait_frames(2);
        check("bounce_f2_valid", 32'(kp_if.key_valid), 0);
        check("bounce_f2_pulses", pulses, base);
        wait_frames(1);
        check("bounce_valid", 32'(kp_if.key_valid), 1);
        check("bounce_code", 32'(kp_if.key_code), 9);
        pressed = '0;
        wait_frames(3);
        check("bounce_pulses", pulses, base + 1);
        check("bounce_released", 32'(kp_if.key_held), 0);

        // Multi-key priority: 3 and 12 together
        base = pulses;
        pressed = key_bit(3) | key_bit(12);
        wait_frames(3);
        check("multi_valid", 32'(kp_if.key_valid), 1);
        check("multi_code", 32'(kp_if.key_code), 3);
        pressed = '0;
        wait_frames(3);
        check("multi_pulses", pulses, base + 1);
        check("multi_released", 32'(kp_if.key_held), 0);

        // Release and lockout
        base = pulses;
        pressed = key_bit(9);
        wait_frames(3);
        check("lock_accept_code", 32'(kp_if.key_code), 9);
        pressed = key_bit(5);
        wait_frames(2);
        check("lock_k5_held", 32'(kp_if.key_held), 1);
        check("lock_k5_pulses", pulses, base + 1);
        pressed = '0;
        wait_frames(2);
        check("lock_none2_held", 32'(kp_if.key_held), 1);
        pressed = key_bit(5);
        wait_frames(1);
        check("lock_k5b_held", 32'(kp_if.key_held), 1);
        pressed = '0;
        wait_frames(2);
        check("lock_none2b_held", 32'(kp_if.key_held), 1);
        wait_frames(1);
        check("lock_release_held", 32'(kp_if.key_held), 0);
        check("lock_code", 32'(kp_if.key_code), 9);
        check("lock_pulses", pulses, base + 1);

        // Reset in the middle of debouncing key 6
        base = pulses;
        pressed = key_bit(6);
        wait_frames(2);
        wait_cycles(6);
        rst_n = 1'b0;
        #1;
        check("mrst_row", 32'(kp_if.row), 32'hE);
        check("mrst_valid", 32'(kp_if.key_valid), 0);
        check("mrst_held", 32'(kp_if.key_held), 0);
        check("mrst_code", 32'(kp_if.key_code), 0);
        wait_cycles(2);
        rst_n = 1'b1;
        check("mrst_pulses", pulses, base);
        wait_frames(2);
        check("mrst_f2_valid", 32'(kp_if.key_valid), 0);
        check("mrst_f2_pulses", pulses, base);
        wait_frames(1);
        check("mrst_valid_after", 32'(kp_if.key_valid), 1);
        check("mrst_code_after", 32'(kp_if.key_code), 6);
        check("mrst_held_after", 32'(kp_if.key_held), 1);
        pressed = '0;
        wait_frames(3);
        check("mrst_final_pulses", pulses, base + 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
